timer_ctrl: RTL
===============

# timer_ctrl

Programmable timer controller that sequences a mod-PRESCALE prescaler and a W-bit down-counter to produce one-shot or periodic expiry events. Software-style control (load, start, stop, mode) is turned into a cycle-exact countdown of `reload × PRESCALE` clock cycles. Sits between control logic (UART/FSM glue, button handlers) and any datapath that needs timed strobes.

## Interface
- `PRESCALE`, default 10: prescaler modulus in clock cycles per tick. Must be ≥ 2. The prescaler is `$clog2(PRESCALE)` bits wide.
- `W`, default 16: width of the reload register and down-counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load_en`  in  1  writes `load_val` into the reload register.
- `load_val`  in  W  reload value, in ticks.
- `mode`  in  1  0 = one-shot, 1 = periodic. Sampled on start and at every expiry.
- `start`  in  1  start/restart request, level-sampled each cycle.
- `stop`  in  1  abort request. Has priority over everything except `reset`.
- `busy`  out  1  high while in RUN.
- `count`  out  W  current down-counter value.
- `tick`  out  1  prescaler wrap strobe: RUN and prescaler == PRESCALE−1.
- `done_tick`  out  1  registered one-cycle expiry pulse.

## Operation
- States: IDLE, RUN.
- Reset effects (synchronous): state IDLE; reload = 0, count = 0, prescaler = 0; `busy`, `tick`, `done_tick` = 0.
- Priority each cycle: reset > stop > start > tick handling.
- `load_en` updates the reload register in any state. In RUN, the new value takes effect only at the next periodic reload or the next start.
- IDLE + `start`:
  - Effective reload is `load_val` if `load_en` is high in the same cycle; otherwise it is the reload register.
  - If the effective reload is 0, `start` is ignored and the block stays IDLE.
  - Otherwise: count ← effective reload, prescaler ← 0, go to RUN.
- RUN prescaler: increments every cycle and wraps PRESCALE−1 → 0. `tick` is asserted in the cycle where the prescaler equals PRESCALE−1.
- RUN + `tick` with count > 1: count decrements at that edge.
- RUN + `tick` with count == 1 (expiry):
  - `done_tick` is high in the next cycle.
  - One-shot: go to IDLE, count ← 0.
  - Periodic: count ← reload register. The prescaler wraps normally, so there is no gap cycle.
- RUN + `stop`:
  - Go to IDLE and hold count at its current value; prescaler ← 0.
  - No `done_tick`, even if `tick` coincides.
- RUN + `start` (no `stop`): restart. count ← effective reload, prescaler ← 0, no `done_tick`. A restart with effective reload 0 behaves as `stop`.
- IDLE: prescaler is held at 0, `tick` = 0, count holds.
- Arithmetic: count never underflows (only reaches 0 via one-shot expiry). Prescaler compare is against PRESCALE−1 exactly.

## Timing
- Numbering: `start` is sampled at the end of cycle 0. `busy` = 1 and prescaler = 0 from cycle 1.
- `tick` occurs at cycles k·PRESCALE, for k ≥ 1.
- Expiry tick is at cycle reload·PRESCALE. `done_tick` is high at cycle reload·PRESCALE+1.
- One-shot: `busy` = 0 from cycle reload·PRESCALE+1.
- Periodic: `done_tick` every reload·PRESCALE cycles exactly.
- `stop` sampled at cycle n → `busy` = 0 at cycle n+1.
- `done_tick` is never wider than one cycle. With PRESCALE ≥ 2, consecutive pulses are at least 2 cycles apart.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use PRESCALE = 4, W = 8.
- One-shot: load_en with load_val = 3, then start at cycle 0, mode = 0 → `tick` at 4, 8, 12; count 3→2→1; `done_tick` only at cycle 13; `busy` low from 13; count = 0.
- Periodic: load 2, mode = 1, start at 0 → `done_tick` at 9, 17, 25; count reloads to 2 at 9 and 17; `busy` stays 1.
- Stop mid-count: load 3, start at 0, stop at cycle 6 → `busy` = 0 and count = 2 from cycle 7; no `tick` or `done_tick` afterwards. Stop at cycle 12 (coincident with the expiry tick) → count holds 1, no `done_tick`.
- Zero and bypass: with reload = 0, start → stays IDLE, `busy` = 0. Then load_en with load_val = 5 and start in the same cycle 0 → `done_tick` at cycle 21.
- Restart and live reload: load 3, start at 0; load_en 7 at cycle 2; start again at cycle 6 → countdown restarts from 7, `done_tick` at cycle 35; nothing at 13.
- Reset mid-run: periodic run, reset at cycle 10 → cycle 11: `busy` = 0, count = 0, `tick` = 0, `done_tick` = 0, reload = 0. A subsequent start without load is ignored.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Control/status bundle for timer_ctrl: software-style commands in, countdown status out.
// The master drives commands; the timer itself is the slave.
interface timer_ctrl_if #(
    parameter int W = 16
);
    logic         load_en;
    logic [W-1:0] load_val;
    logic         mode;
    logic         start;
    logic         stop;
    logic         busy;
    logic [W-1:0] count;
    logic         tick;
    logic         done_tick;

    modport master (
        output load_en, load_val, mode, start, stop,
        input  busy, count, tick, done_tick
    );

    modport slave (
        input  load_en, load_val, mode, start, stop,
        output busy, count, tick, done_tick
    );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable timer: mod-PRESCALE prescaler feeding a W-bit down-counter, producing
// one-shot or periodic expiry pulses after reload*PRESCALE clock cycles.
module timer_ctrl #(
    parameter int PRESCALE = 10,
    parameter int W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    timer_ctrl_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  reload_q, reload_d;
    logic [W-1:0]  eff_reload;
    logic          done_q, done_d;
    logic          tick_w;

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign tick_w        = (state_q == RUN) && (pre_q == PRE_MAX);
    assign bus.busy      = (state_q == RUN);
    assign bus.count     = count_q;
    assign bus.tick      = tick_w;
    assign bus.done_tick = done_q;

    // A load in the same cycle as start bypasses the reload register.
    assign eff_reload = bus.load_en ? bus.load_val : reload_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        pre_d    = pre_q;
        count_d  = count_q;
        reload_d = eff_reload;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                pre_d = '0;
                if (!bus.stop && bus.start && (eff_reload != '0)) begin
                    state_d = RUN;
                    count_d = eff_reload;
                end
            end
            RUN: begin
                if (bus.stop || (bus.start && (eff_reload == '0))) begin
                    state_d = IDLE;
                    pre_d   = '0;
                end else if (bus.start) begin
                    count_d = eff_reload;
                    pre_d   = '0;
                end else begin
                    pre_d = tick_w ? '0 : pre_q + PW'(1);
                    if (tick_w) begin
                        if (count_q > W'(1)) begin
                            count_d = count_q - W'(1);
                        end else begin
                            // Expiry: periodic mode reloads from the register, not a same-cycle load.
                            done_d = 1'b1;
                            if (bus.mode) begin
                                count_d = reload_q;
                            end else begin
                                state_d = IDLE;
                                count_d = '0;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end
endmodule
